fnd_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit 7-segment display. It generates the 3-bit digit position that feeds the digit-select decoder, and in the same registered cycle presents that digit's BCD nibble and decimal-point bit to the segment encoder. Positions 0–3 form page 0 (lower four digits) and positions 4–7 form page 1 (upper four digits). The page is switched only at a scan-frame boundary, so the display never shows a mixed frame.

---
 rtl/fnd_scan_ctrl.sv | 103 ++++++++++
 tb/tb_fnd_scan_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_ctrl.sv
// Digit scan controller for a 4-digit 7-segment display with two 4-digit pages.
// Optional dot blinking at scan index 2 is enabled by defining FND_DOT_BLINK_EN.
module fnd_scan_ctrl #(
  parameter int P_CLK_HZ   = 100_000_000,
  parameter int P_SCAN_HZ  = 4_000,
  parameter int P_BLINK_HZ = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_fndData,
  input  logic [7:0]  i_dot,
  input  logic        i_page,
  output logic [2:0]  o_digitPosition,
  output logic [3:0]  o_bcd,
  output logic        o_dot,
  output logic        o_frameStart
);

  localparam int N  = P_CLK_HZ / P_SCAN_HZ;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] PRESC_LAST = CW'(N - 1);

  logic [CW-1:0] presc_reg, presc_next;
  logic          tick;
  logic [1:0]    index_reg, index_next;
  logic          page_reg, page_next;
  logic [2:0]    pos_next;
  logic          dot_next;
  logic [3:0]    digit [8];

  logic [2:0]    pos_reg;
  logic [3:0]    bcd_reg;
  logic          dot_reg;
  logic          frame_reg;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
      assign digit[gi] = i_fndData[4*gi +: 4];
    end
  endgenerate

  // The page only follows i_page on the wrap to index 0, so frames never mix pages.
  always_comb begin
    tick       = (presc_reg == PRESC_LAST);
    presc_next = tick ? '0 : presc_reg + 1'b1;
    index_next = index_reg + 2'd1;
    page_next  = (index_reg == 2'd3) ? i_page : page_reg;
    pos_next   = {page_next, index_next};
  end

`ifdef FND_DOT_BLINK_EN
  localparam int H  = P_CLK_HZ / (2 * P_BLINK_HZ);
  localparam int HW = (H > 1) ? $clog2(H) : 1;
  localparam logic [HW-1:0] BLINK_LAST = HW'(H - 1);

  logic [HW-1:0] blink_reg;
  logic          phase_reg;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      blink_reg <= '0;
      phase_reg <= 1'b0;
    end else if (blink_reg == BLINK_LAST) begin
      blink_reg <= '0;
      phase_reg <= ~phase_reg;
    end else begin
      blink_reg <= blink_reg + 1'b1;
    end
  end

  assign dot_next = (index_next == 2'd2) ? (i_dot[pos_next] & phase_reg) : i_dot[pos_next];
`else
  assign dot_next = i_dot[pos_next];
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      presc_reg <= '0;
      index_reg <= 2'd0;
      page_reg  <= 1'b0;
      pos_reg   <= 3'd0;
      bcd_reg   <= 4'h0;
      dot_reg   <= 1'b0;
      frame_reg <= 1'b0;
    end else begin
      presc_reg <= presc_next;
      frame_reg <= tick && (index_next == 2'd0);
      if (tick) begin
        index_reg <= index_next;
        page_reg  <= page_next;
        pos_reg   <= pos_next;
        bcd_reg   <= digit[pos_next];
        dot_reg   <= dot_next;
      end
    end
  end

  assign o_digitPosition = pos_reg;
  assign o_bcd           = bcd_reg;
  assign o_dot           = dot_reg;
  assign o_frameStart    = frame_reg;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl with N = 4 and H = 10; dot expectations follow FND_DOT_BLINK_EN.
module tb_fnd_scan_ctrl;

  localparam int N = 4;
  localparam int H = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fnd_data;
  logic [7:0]  dot_in;
  logic        page_in;
  logic [2:0]  pos_out;
  logic [3:0]  bcd_out;
  logic        dot_out;
  logic        fs_out;

  fnd_scan_ctrl #(
    .P_CLK_HZ  (100),
    .P_SCAN_HZ (25),
    .P_BLINK_HZ(5)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_fndData      (fnd_data),
    .i_dot          (dot_in),
    .i_page         (page_in),
    .o_digitPosition(pos_out),
    .o_bcd          (bcd_out),
    .o_dot          (dot_out),
    .o_frameStart   (fs_out)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; used only to predict the blink phase.
  int edge_n;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  typedef struct {
    int          chg;
    logic        page;
    logic [31:0] fnd;
    logic [7:0]  dot;
    logic [2:0]  pos;
    logic [3:0]  bcd;
    logic        edot;
    logic        fs;
  } vec_t;

  typedef struct {
    logic [2:0] pos;
    logic [3:0] bcd;
    logic       dot;
    logic       fs;
  } exp_t;

  vec_t tbl [24];
  exp_t sb [$];
  exp_t prev_exp;
  exp_t cur;

  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(int chg, logic page, logic [31:0] fnd, logic [7:0] dot,
                              logic [2:0] pos, logic [3:0] bcd, logic edot, logic fs);
    vec_t v;
    v.chg = chg; v.page = page; v.fnd = fnd; v.dot = dot;
    v.pos = pos; v.bcd = bcd; v.edot = edot; v.fs = fs;
    return v;
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got pos=%0d bcd=%h dot=%b fs=%b, want pos=%0d bcd=%h dot=%b fs=%b",
               name, act[8:6], act[5:2], act[1], act[0], exp[8:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [8:0] outs();
    return {pos_out, bcd_out, dot_out, fs_out};
  endfunction

  function automatic logic [8:0] pack(exp_t e);
    return {e.pos, e.bcd, e.dot, e.fs};
  endfunction

  localparam logic [31:0] D1 = 32'h8765_4321;
  localparam logic [31:0] D2 = 32'h8765_4329;
  localparam logic [31:0] D3 = 32'hFEDC_BA09;

  initial begin
    int tick_edge;
    int found;

    tbl[0]  = mk(0, 1'b0, D1, 8'h04, 3'd1, 4'h2, 1'b0, 1'b0);
    tbl[1]  = mk(0, 1'b0, D1, 8'h04, 3'd2, 4'h3, 1'b1, 1'b0);
    tbl[2]  = mk(0, 1'b0, D1, 8'h04, 3'd3, 4'h4, 1'b0, 1'b0);
    tbl[3]  = mk(0, 1'b0, D1, 8'h04, 3'd0, 4'h1, 1'b0, 1'b1);
    tbl[4]  = mk(0, 1'b0, D1, 8'h04, 3'd1, 4'h2, 1'b0, 1'b0);
    tbl[5]  = mk(0, 1'b1, D1, 8'h04, 3'd2, 4'h3, 1'b1, 1'b0);
    tbl[6]  = mk(0, 1'b1, D1, 8'h04, 3'd3, 4'h4, 1'b0, 1'b0);
    tbl[7]  = mk(0, 1'b1, D1, 8'h04, 3'd4, 4'h5, 1'b0, 1'b1);
    tbl[8]  = mk(0, 1'b1, D1, 8'h04, 3'd5, 4'h6, 1'b0, 1'b0);
    tbl[9]  = mk(0, 1'b1, D1, 8'h04, 3'd6, 4'h7, 1'b0, 1'b0);
    tbl[10] = mk(0, 1'b1, D1, 8'h04, 3'd7, 4'h8, 1'b0, 1'b0);
    tbl[11] = mk(0, 1'b0, D1, 8'h04, 3'd0, 4'h1, 1'b0, 1'b1);
    tbl[12] = mk(0, 1'b0, D1, 8'h04, 3'd1, 4'h2, 1'b0, 1'b0);
    tbl[13] = mk(0, 1'b0, D1, 8'h04, 3'd2, 4'h3, 1'b1, 1'b0);
    tbl[14] = mk(0, 1'b0, D1, 8'h04, 3'd3, 4'h4, 1'b0, 1'b0);
    tbl[15] = mk(0, 1'b0, D1, 8'h04, 3'd0, 4'h1, 1'b0, 1'b1);
    tbl[16] = mk(2, 1'b0, D2, 8'h04, 3'd1, 4'h2, 1'b0, 1'b0);
    tbl[17] = mk(0, 1'b0, D2, 8'h04, 3'd2, 4'h3, 1'b1, 1'b0);
    tbl[18] = mk(0, 1'b0, D2, 8'h04, 3'd3, 4'h4, 1'b0, 1'b0);
    tbl[19] = mk(0, 1'b0, D2, 8'h04, 3'd0, 4'h9, 1'b0, 1'b1);
    tbl[20] = mk(0, 1'b0, D3, 8'hFB, 3'd1, 4'h0, 1'b1, 1'b0);
    tbl[21] = mk(0, 1'b0, D3, 8'hFB, 3'd2, 4'hA, 1'b0, 1'b0);
    tbl[22] = mk(0, 1'b0, D3, 8'hFB, 3'd3, 4'hB, 1'b1, 1'b0);
    tbl[23] = mk(0, 1'b0, D3, 8'hFB, 3'd0, 4'h9, 1'b1, 1'b1);

    rst_n    = 1'b0;
    fnd_data = D1;
    dot_in   = 8'h04;
    page_in  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", outs(), 9'd0);
    rst_n = 1'b1;

    prev_exp = '{pos: 3'd0, bcd: 4'h0, dot: 1'b0, fs: 1'b0};
    for (int i = 0; i < 24; i++) begin
      tick_edge = edge_n + N;
      cur.pos = tbl[i].pos;
      cur.bcd = tbl[i].bcd;
      cur.fs  = tbl[i].fs;
`ifdef FND_DOT_BLINK_EN
      cur.dot = (tbl[i].pos[1:0] == 2'd2) ? (tbl[i].edot & (((tick_edge - 1) / H) % 2 == 1))
                                          : tbl[i].edot;
`else
      cur.dot = tbl[i].edot;
`endif
      sb.push_back(cur);
      for (int k = 0; k < N; k++) begin
        if (k == tbl[i].chg) begin
          page_in  = tbl[i].page;
          fnd_data = tbl[i].fnd;
          dot_in   = tbl[i].dot;
        end
        @(posedge clk);
        @(negedge clk);
        if (k < N - 1) begin
          check($sformatf("hold[%0d.%0d]", i, k), outs(),
                {prev_exp.pos, prev_exp.bcd, prev_exp.dot, 1'b0});
        end else if (sb.size() == 0) begin
          check($sformatf("sb_empty[%0d]", i), outs(), ~outs());
        end else begin
          prev_exp = sb.pop_front();
          check($sformatf("tick[%0d]", i), outs(), pack(prev_exp));
        end
      end
    end

    // Mid-frame reset while showing position 7 must clear outputs before the next edge.
    page_in  = 1'b1;
    dot_in   = 8'h04;
    found    = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (pos_out == 3'd7) found = 1;
    end
    check("reach_pos7", {pos_out, 6'd0}, {3'd7, 6'd0});
    #2 rst_n = 1'b0;
    #1 check("async_clear", outs(), 9'd0);
    repeat (2) @(negedge clk);

    // After release the scan restarts on page 0; with i_page toggling every
    // cycle only the value present at the wrap edge selects the page.
    page_in = 1'b0;
    rst_n   = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      page_in = (e % 2 == 0);
      @(posedge clk);
      @(negedge clk);
      if (e == 3)  check("restart_hold", outs(), 9'd0);
      if (e == 4)  check("restart_pos1", outs(), {3'd1, 4'h0, 1'b0, 1'b0});
      if (e == 16) check("toggle_wrap", outs(), {3'd4, 4'hC, 1'b0, 1'b1});
      if (e == 17) check("toggle_fs_end", outs(), {3'd4, 4'hC, 1'b0, 1'b0});
      if (e == 20) check("toggle_hold_page", outs(), {3'd5, 4'hD, 1'b0, 1'b0});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 time units, want finish");
    $fatal(1, "watchdog");
  end

endmodule
